// File: rtl/call_stack.sv
// LIFO call/return stack with a zero-latency top-of-stack read and sticky misuse flags.
// Supports push, pop, push+pop (replace top) and synchronous clear; it never stalls.
module call_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   input  logic                         err_clr,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    top_idx;
   logic             ovf_set, unf_set;
   logic             is_empty, is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == (AW+1)'(DEPTH));
   // At count == DEPTH the low bits are zero, so the subtraction lands on DEPTH-1.
   assign top_idx  = count_q[AW-1:0] - AW'(1);

   always_comb begin
      count_d = count_q;
      wr_en   = 1'b0;
      wr_addr = '0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (push && pop) begin
         if (!is_empty) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
         end else begin
            wr_en   = 1'b1;
            wr_addr = '0;
            count_d = (AW+1)'(1);
            unf_set = 1'b1;
         end
      end else if (push) begin
         if (is_full) begin
            ovf_set = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_addr = count_q[AW-1:0];
            count_d = count_q + (AW+1)'(1);
         end
      end else if (pop) begin
         if (is_empty) begin
            unf_set = 1'b1;
         end else begin
            count_d = count_q - (AW+1)'(1);
         end
      end
      // A new error in the same cycle as err_clr wins.
      overflow_d  = ovf_set | (overflow_q  & ~err_clr);
      underflow_d = unf_set | (underflow_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage has no reset; dout is masked while empty so stale contents never leak.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= din;
      end
   end

   assign dout      = is_empty ? '0 : mem_q[top_idx];
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
